hicore_rob_ctrl: RTL and testbench

//  In-order reorder-buffer controller between the issue stage and the register-file/CSR write port.

---
 rtl/hicore_rob_pkg.sv | 27 ++
 rtl/hicore_rob_ptr.sv | 36 +++
 rtl/hicore_rob_ctrl.sv | 133 +++++++++++++
 tb/tb_hicore_rob_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hicore_rob_pkg.sv
// Shared ROB definitions: geometry, field widths and the packed entry layouts
// exchanged with the issue and commit stages.
package hicore_rob_pkg;

  localparam int DEPTH   = 8;
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int RFIDX_W = 5;
  localparam int REG_W   = 32;

  localparam logic [PTR_W:0] ROB_FULL = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0] CNT_ONE  = (PTR_W + 1)'(1);

  // Fields captured at allocation time.
  typedef struct packed {
    logic               rd_need;
    logic [RFIDX_W-1:0] rd_idx;
    logic               fence_i;
    logic               mret;
  } rob_issue_t;

  // Fields captured from the writeback bus.
  typedef struct packed {
    logic [REG_W-1:0] data;
    logic             excp;
  } rob_wb_t;

endpackage

// File: rtl/hicore_rob_ptr.sv
// Wrapping ROB pointer: increments modulo 2**PTR_W, clear overrides increment.
module hicore_rob_ptr #(
  parameter int PTR_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [PTR_W-1:0] ptr_o
);

  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_d;

  // NOTE: combinational next-state uses blocking '=' with a default first so
  // no latch is inferred; the register below uses non-blocking '<=' only.
  always_comb begin
    ptr_d = ptr_q;
    if (clr_i) begin
      ptr_d = '0;
    end else if (inc_i) begin
      ptr_d = ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/hicore_rob_ctrl.sv
// In-order reorder-buffer controller: allocates at issue, records out-of-order
// writebacks, retires the oldest completed entry, and flushes everything on demand.
module hicore_rob_ctrl
  import hicore_rob_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               alloc_valid,
  output logic               alloc_ready,
  input  logic               alloc_rd_need,
  input  logic [RFIDX_W-1:0] alloc_rd_idx,
  input  logic               alloc_fence_i,
  input  logic               alloc_mret,
  output logic [PTR_W-1:0]   alloc_ptr,
  input  logic               wb_valid,
  input  logic [PTR_W-1:0]   wb_ptr,
  input  logic [REG_W-1:0]   wb_data,
  input  logic               wb_excp,
  output logic               cmt_valid,
  input  logic               cmt_ready,
  output logic [PTR_W-1:0]   cmt_ptr,
  output logic               cmt_rd_need,
  output logic [RFIDX_W-1:0] cmt_rd_idx,
  output logic [REG_W-1:0]   cmt_data,
  output logic               cmt_excp,
  output logic               cmt_fence_i,
  output logic               cmt_mret,
  input  logic               flush,
  output logic               rob_empty
);

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W:0]   count_q;
  logic [PTR_W:0]   count_d;
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] valid_d;
  logic [DEPTH-1:0] done_q;
  logic [DEPTH-1:0] done_d;
  rob_issue_t       issue_q [DEPTH];
  rob_wb_t          wbres_q [DEPTH];

  logic alloc_fire;
  logic wb_hit;
  logic cmt_fire;

  assign alloc_ready = (count_q != ROB_FULL);
  assign cmt_valid   = valid_q[head] & done_q[head];

  assign alloc_fire = alloc_valid & alloc_ready & ~flush;
  assign cmt_fire   = cmt_valid & cmt_ready & ~flush;
  // A writeback aimed at the slot being allocated this cycle is stale and dropped.
  assign wb_hit     = wb_valid & valid_q[wb_ptr] & ~flush
                    & ~(alloc_fire & (wb_ptr == tail));

  hicore_rob_ptr #(.PTR_W(PTR_W)) u_head (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (flush),
    .inc_i (cmt_fire),
    .ptr_o (head)
  );

  hicore_rob_ptr #(.PTR_W(PTR_W)) u_tail (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (flush),
    .inc_i (alloc_fire),
    .ptr_o (tail)
  );

  always_comb begin
    valid_d = valid_q;
    done_d  = done_q;
    count_d = count_q;
    if (flush) begin
      valid_d = '0;
      done_d  = '0;
      count_d = '0;
    end else begin
      if (cmt_fire) begin
        valid_d[head] = 1'b0;
      end
      if (wb_hit) begin
        done_d[wb_ptr] = 1'b1;
      end
      if (alloc_fire) begin
        valid_d[tail] = 1'b1;
        done_d[tail]  = 1'b0;
      end
      unique case ({alloc_fire, cmt_fire})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      done_q  <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      done_q  <= done_d;
      count_q <= count_d;
    end
  end

  // NOTE: payload flops carry no reset; they are only observed once valid/done
  // say so, and leaving them unreset keeps the reset tree small.
  always_ff @(posedge clk) begin
    if (alloc_fire) begin
      issue_q[tail] <= '{rd_need: alloc_rd_need, rd_idx: alloc_rd_idx,
                         fence_i: alloc_fence_i, mret: alloc_mret};
    end
    if (wb_hit) begin
      wbres_q[wb_ptr] <= '{data: wb_data, excp: wb_excp};
    end
  end

  assign alloc_ptr   = tail;
  assign cmt_ptr     = head;
  assign cmt_rd_need = issue_q[head].rd_need;
  assign cmt_rd_idx  = issue_q[head].rd_idx;
  assign cmt_fence_i = issue_q[head].fence_i;
  assign cmt_mret    = issue_q[head].mret;
  assign cmt_data    = wbres_q[head].data;
  assign cmt_excp    = wbres_q[head].excp;
  assign rob_empty   = (count_q == '0);

endmodule

// File: tb/tb_hicore_rob_ctrl.sv
// Scoreboard bench for hicore_rob_ctrl: an in-order queue of in-flight instructions
// is the reference; a negedge monitor compares every retire and status output.
module tb_hicore_rob_ctrl;
  import hicore_rob_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n;
  logic               alloc_valid;
  logic               alloc_ready;
  logic               alloc_rd_need;
  logic [RFIDX_W-1:0] alloc_rd_idx;
  logic               alloc_fence_i;
  logic               alloc_mret;
  logic [PTR_W-1:0]   alloc_ptr;
  logic               wb_valid;
  logic [PTR_W-1:0]   wb_ptr;
  logic [REG_W-1:0]   wb_data;
  logic               wb_excp;
  logic               cmt_valid;
  logic               cmt_ready;
  logic [PTR_W-1:0]   cmt_ptr;
  logic               cmt_rd_need;
  logic [RFIDX_W-1:0] cmt_rd_idx;
  logic [REG_W-1:0]   cmt_data;
  logic               cmt_excp;
  logic               cmt_fence_i;
  logic               cmt_mret;
  logic               flush;
  logic               rob_empty;

  hicore_rob_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .alloc_valid   (alloc_valid),
    .alloc_ready   (alloc_ready),
    .alloc_rd_need (alloc_rd_need),
    .alloc_rd_idx  (alloc_rd_idx),
    .alloc_fence_i (alloc_fence_i),
    .alloc_mret    (alloc_mret),
    .alloc_ptr     (alloc_ptr),
    .wb_valid      (wb_valid),
    .wb_ptr        (wb_ptr),
    .wb_data       (wb_data),
    .wb_excp       (wb_excp),
    .cmt_valid     (cmt_valid),
    .cmt_ready     (cmt_ready),
    .cmt_ptr       (cmt_ptr),
    .cmt_rd_need   (cmt_rd_need),
    .cmt_rd_idx    (cmt_rd_idx),
    .cmt_data      (cmt_data),
    .cmt_excp      (cmt_excp),
    .cmt_fence_i   (cmt_fence_i),
    .cmt_mret      (cmt_mret),
    .flush         (flush),
    .rob_empty     (rob_empty)
  );

  typedef struct {
    int               ptr;
    bit               rd_need;
    int               rd_idx;
    bit               fence_i;
    bit               mret;
    bit               done;
    logic [REG_W-1:0] data;
    bit               excp;
  } exp_t;

  exp_t exp_q[$];
  int   m_tail  = 0;
  int   n_cmp   = 0;
  int   n_fail  = 0;
  bit   mon_en  = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic rand_alloc_fields();
    alloc_rd_need = 1'($urandom_range(0, 1));
    alloc_rd_idx  = RFIDX_W'($urandom_range(0, 31));
    alloc_fence_i = ($urandom_range(0, 7) == 0);
    alloc_mret    = ($urandom_range(0, 7) == 0);
  endtask

  task automatic do_wb(input int p, input logic [REG_W-1:0] d, input bit e);
    wb_valid = 1'b1;
    wb_ptr   = PTR_W'(p);
    wb_data  = d;
    wb_excp  = e;
  endtask

  // Advance one clock and apply the reference rules to the model.
  task automatic tick();
    bit               a_ok;
    bit               wv;
    bit               we;
    bit               fl;
    bit               rn;
    int               wp;
    logic [REG_W-1:0] wd;
    exp_t             e;
    rn   = rst_n;
    fl   = flush;
    wv   = wb_valid;
    wp   = int'(wb_ptr);
    wd   = wb_data;
    we   = wb_excp;
    a_ok = alloc_valid && (exp_q.size() != DEPTH);
    e = '{ptr: m_tail, rd_need: alloc_rd_need, rd_idx: int'(alloc_rd_idx),
          fence_i: alloc_fence_i, mret: alloc_mret, done: 1'b0, data: '0, excp: 1'b0};
    @(posedge clk);
    #1;
    if (!rn || fl) begin
      exp_q.delete();
      m_tail = 0;
    end else begin
      if (wv) begin
        foreach (exp_q[i]) begin
          if (exp_q[i].ptr == wp) begin
            exp_q[i].done = 1'b1;
            exp_q[i].data = wd;
            exp_q[i].excp = we;
          end
        end
      end
      if (a_ok) begin
        exp_q.push_back(e);
        m_tail = (m_tail + 1) % DEPTH;
      end
    end
    alloc_valid = 1'b0;
    wb_valid    = 1'b0;
    flush       = 1'b0;
    rst_n       = 1'b1;
    mon_en      = 1'b1;
  endtask

  // Monitor: compares status outputs every cycle and pops on each retire.
  initial begin
    bit head_done;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        head_done = (exp_q.size() > 0) && exp_q[0].done;
        check("alloc_ready", 64'(alloc_ready), 64'(exp_q.size() != DEPTH));
        check("rob_empty",   64'(rob_empty),   64'(exp_q.size() == 0));
        check("alloc_ptr",   64'(alloc_ptr),   64'(m_tail));
        check("cmt_valid",   64'(cmt_valid),   64'(head_done));
        if (head_done) begin
          check("cmt_ptr",     64'(cmt_ptr),     64'(exp_q[0].ptr));
          check("cmt_rd_need", 64'(cmt_rd_need), 64'(exp_q[0].rd_need));
          check("cmt_rd_idx",  64'(cmt_rd_idx),  64'(exp_q[0].rd_idx));
          check("cmt_data",    64'(cmt_data),    64'(exp_q[0].data));
          check("cmt_excp",    64'(cmt_excp),    64'(exp_q[0].excp));
          check("cmt_fence_i", 64'(cmt_fence_i), 64'(exp_q[0].fence_i));
          check("cmt_mret",    64'(cmt_mret),    64'(exp_q[0].mret));
          if (cmt_ready && rst_n && !flush) begin
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; alloc_valid = 1'b0; wb_valid = 1'b0; flush = 1'b0; cmt_ready = 1'b0;
    alloc_rd_need = 1'b0; alloc_rd_idx = '0; alloc_fence_i = 1'b0; alloc_mret = 1'b0;
    wb_ptr = '0; wb_data = '0; wb_excp = 1'b0;
    tick();

    // Fill with no writeback, then one refused allocation.
    repeat (9) begin
      alloc_valid = 1'b1; rand_alloc_fields(); tick();
    end

    // Out-of-order completion: ptr2 then ptr0, ptr1 blocks retirement.
    flush = 1'b1; tick();
    repeat (3) begin
      alloc_valid = 1'b1; rand_alloc_fields(); tick();
    end
    cmt_ready = 1'b1;
    do_wb(2, REG_W'($urandom), 1'b0); tick();
    do_wb(0, 32'h0000_00A5, 1'b0); tick();
    repeat (3) tick();
    do_wb(1, REG_W'($urandom), 1'b0); tick();
    repeat (3) tick();

    // Full ROB: retire and alloc offered together, then alloc wraps to ptr 0.
    cmt_ready = 1'b0; flush = 1'b1; tick();
    repeat (8) begin
      alloc_valid = 1'b1; rand_alloc_fields(); tick();
    end
    do_wb(0, REG_W'($urandom), 1'b0); tick();
    cmt_ready = 1'b1; alloc_valid = 1'b1; rand_alloc_fields(); tick();
    alloc_valid = 1'b1; rand_alloc_fields(); tick();
    tick();

    // Writeback of the head coinciding with flush.
    flush = 1'b1; tick();
    cmt_ready = 1'b0;
    repeat (5) begin
      alloc_valid = 1'b1; rand_alloc_fields(); tick();
    end
    cmt_ready = 1'b1; do_wb(0, REG_W'($urandom), 1'b0); flush = 1'b1; tick();
    tick();

    // Writeback to unallocated ptr 6 must not pre-complete a later allocation.
    for (int i = 0; i < 6; i++) begin
      alloc_valid = 1'b1; rand_alloc_fields(); tick();
    end
    for (int i = 0; i < 6; i++) begin
      do_wb(i, REG_W'($urandom), 1'b0); tick();
    end
    repeat (2) tick();
    do_wb(6, 32'hDEAD_BEEF, 1'b1); tick();
    alloc_valid = 1'b1; rand_alloc_fields(); tick();
    repeat (3) tick();
    do_wb(6, 32'h1234_5678, 1'b0); tick();
    tick();

    // mret with exception, then reset in the middle of traffic.
    alloc_valid = 1'b1; rand_alloc_fields(); alloc_mret = 1'b1; tick();
    do_wb(7, REG_W'($urandom), 1'b1); tick();
    repeat (2) tick();
    cmt_ready = 1'b0;
    repeat (3) begin
      alloc_valid = 1'b1; rand_alloc_fields(); tick();
    end
    do_wb(0, REG_W'($urandom), 1'b0); rst_n = 1'b0; tick();
    tick();

    // Randomised traffic.
    for (int c = 0; c < 4000; c++) begin
      rst_n       = ($urandom_range(0, 299) != 0);
      flush       = ($urandom_range(0, 59) == 0);
      alloc_valid = 1'($urandom_range(0, 1));
      rand_alloc_fields();
      cmt_ready   = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) != 0) begin
        if (exp_q.size() > 0 && $urandom_range(0, 3) != 0) begin
          do_wb(exp_q[$urandom_range(0, exp_q.size() - 1)].ptr, REG_W'($urandom),
                ($urandom_range(0, 7) == 0));
        end else begin
          do_wb($urandom_range(0, DEPTH - 1), REG_W'($urandom), 1'($urandom_range(0, 1)));
        end
      end
      tick();
    end
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
